hsv_to_rgb: RTL and testbench
=============================

Name: hsv_to_rgb

Overview:
- Pipelined inverse of the team's RGB-to-HSV colour converter: rebuilds 8-bit R/G/B from the chroma-scaled hue (H), chroma (S = max-min) and value (V = max).
- Sits in the video path after HSV-domain processing (thresholding, hue shift) and before the VGA/frame-buffer writer.
- Streams one pixel per clock using valid/ready flow control.
- Carries start-of-frame and end-of-line sideband bits aligned with the pixel data.

Parameters:
- HW, 14: hue input width, signed.
- CW, 8: channel width for S, V, R, G and B.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block accepts the input this cycle.
- H_i  in  14  signed hue in chroma units:
  - R-max sector: G-B.
  - G-max sector: B-R+2S.
  - B-max sector: R-G+4S.
- S_i  in  8  chroma (max-min).
- V_i  in  8  value (max).
- sof_i  in  1  start-of-frame marker.
- eol_i  in  1  end-of-line marker.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the output.
- R_o  out  8  reconstructed red.
- G_o  out  8  reconstructed green.
- B_o  out  8  reconstructed blue.
- sof_o  out  1  delayed sof_i.
- eol_o  out  1  delayed eol_i.

Behaviour:
- Reset (rst_n=0 at a clock edge): all stage valids, out_valid, R_o, G_o, B_o, sof_o and eol_o go to 0.
  - in_ready is 0 during reset and returns to 1 on the first cycle after release.
  - Reset mid-stream discards all in-flight pixels; no partial output is produced.
- Pipeline: 3 register stages. Latency is 3 cycles from an accepted input (in_valid & in_ready) to out_valid, when there is no stall.
- Flow control:
  - en = !out_valid | out_ready; in_ready = en.
  - All stages advance only when en=1. When en=0, every stage register holds and the outputs stay stable.
  - Bubbles are not collapsed.
  - A transfer occurs on any cycle with out_valid & out_ready.
- Stage 1 (register and clamp):
  - C = min(S_i, V_i); m = V_i - C.
  - H clamped to [-C, 5C]. Compare in 14-bit signed, with C zero-extended.
  - Register H, C, V, m and the sideband bits.
- Stage 2 (sector select). Exactly one sector is chosen, in this order:
  - H < C: sector R, x = H.
  - else H < 3C: sector G, x = H - 2C.
  - else: sector B, x = H - 4C.
  - Register the sector (2-bit encoding R=0, G=1, B=2), x (signed, |x| <= C), V and m.
- Stage 3 (channel build, outputs registered). The max channel = V; the remaining two channels are assigned by the sign of x:
  - Sector R, x>=0: R=V, G=m+x, B=m. Sector R, x<0: R=V, G=m, B=m-x.
  - Sector G, x>=0: G=V, B=m+x, R=m. Sector G, x<0: G=V, R=m-x, B=m.
  - Sector B, x>=0: B=V, R=m+x, G=m. Sector B, x<0: B=V, G=m-x, R=m.
  - Results never exceed V by construction. Still saturate each channel to 8 bits: sum >255 -> 255.
- Boundary conditions:
  - C=0 (grey): H is forced to 0, giving R=G=B=V.
  - V=0: output is all zeros.
  - H == C or H == 3C: falls into the later sector. Both sectors yield the same colour.
  - S_i > V_i is illegal upstream; it is handled by the clamp C = V_i.
- Sideband bits travel in lock-step with their pixel and are never reordered.

Test Plan:
- Reset, then in_valid for H=0, S=255, V=255 (red) with out_ready=1 -> out_valid exactly 3 cycles after acceptance; R,G,B = 255,0,0.
- H=510, S=255, V=255 -> 0,255,0. H=-100, S=200, V=220 -> 220,20,120. H=900, S=200, V=220 -> 120,20,220.
- Grey: S=0, V=128, H=37 -> 128,128,128. Clamp: S=250, V=100, H=-500 -> C=100, H=-100 -> 100,0,100.
- Back-to-back stream of 16 pixels with out_ready toggling 1,0,0,1 -> no loss or duplication, outputs stable while stalled, sof_o/eol_o aligned with their pixels, in_ready=0 exactly when out_valid & !out_ready.
- Assert rst_n=0 for one cycle with 3 pixels in flight -> next cycle out_valid=0 and all outputs 0; no stale pixel appears after release.
- Sweep all V in 0..255 and S in 0..V, with H on the sector boundaries -C, C, 3C and 5C -> compare against a reference model; every channel <= V and min channel == V-S.

Source files
------------

// File: rtl/hsv_to_rgb_if.sv
// Pixel stream bundle for the HSV-to-RGB converter: HSV input side with sideband,
// RGB output side with sideband, and the valid/ready pair on each side.
interface hsv_to_rgb_if #(
    parameter int HW = 14,
    parameter int CW = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [HW-1:0] H_i;
    logic [CW-1:0]        S_i;
    logic [CW-1:0]        V_i;
    logic                 sof_i;
    logic                 eol_i;
    logic                 out_valid;
    logic                 out_ready;
    logic [CW-1:0]        R_o;
    logic [CW-1:0]        G_o;
    logic [CW-1:0]        B_o;
    logic                 sof_o;
    logic                 eol_o;

    modport master (
        output in_valid, H_i, S_i, V_i, sof_i, eol_i, out_ready,
        input  in_ready, out_valid, R_o, G_o, B_o, sof_o, eol_o
    );

    modport slave (
        input  in_valid, H_i, S_i, V_i, sof_i, eol_i, out_ready,
        output in_ready, out_valid, R_o, G_o, B_o, sof_o, eol_o
    );
endinterface

// File: rtl/hsv_to_rgb.sv
// Three-stage HSV-to-RGB converter: clamp, sector select, channel build.
// One pixel per clock; a single enable stalls the whole pipe when the output is blocked.
module hsv_to_rgb #(
    parameter int HW = 14,
    parameter int CW = 8
) (
    input logic         clk,
    input logic         rst_n,
    hsv_to_rgb_if.slave bus
);
    typedef enum logic [1:0] {
        SEC_R = 2'd0,
        SEC_G = 2'd1,
        SEC_B = 2'd2
    } sector_e;

    localparam logic signed [HW-1:0] CHAN_MAX_S = {{(HW-CW){1'b0}}, {CW{1'b1}}};
    localparam logic signed [HW-1:0] ZERO_S     = {HW{1'b0}};

    function automatic logic [CW-1:0] sat_chan(input logic signed [HW-1:0] val);
        logic [CW-1:0] res;
        if (val > CHAN_MAX_S) begin
            res = {CW{1'b1}};
        end else if (val < ZERO_S) begin
            res = {CW{1'b0}};
        end else begin
            res = val[CW-1:0];
        end
        return res;
    endfunction

    logic                 en_s;
    logic                 out_valid_q;

    // Stage 1 signals
    logic [CW-1:0]        c_s;
    logic signed [HW-1:0] c_ext_s;
    logic signed [HW-1:0] c5_s;
    logic signed [HW-1:0] cneg_s;
    logic signed [HW-1:0] h1_d, h1_q;
    logic [CW-1:0]        c1_d, c1_q;
    logic [CW-1:0]        v1_d, v1_q;
    logic [CW-1:0]        m1_d, m1_q;
    logic                 vld1_d, vld1_q;
    logic                 sof1_d, sof1_q;
    logic                 eol1_d, eol1_q;

    // Stage 2 signals
    logic signed [HW-1:0] c1x_s;
    sector_e              sec2_d, sec2_q;
    logic signed [HW-1:0] x2_d, x2_q;
    logic [CW-1:0]        v2_q, m2_q;
    logic                 vld2_q, sof2_q, eol2_q;

    // Stage 3 signals
    logic signed [HW-1:0] m_ext_s;
    logic signed [HW-1:0] add_s;
    logic signed [HW-1:0] sub_s;
    logic [CW-1:0]        r3_d, g3_d, b3_d;
    logic [CW-1:0]        r_q, g_q, b_q;
    logic                 sof_q, eol_q;

    assign en_s         = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = en_s & rst_n;

    // Stage 1 next state: chroma from min(S,V), hue clamped to the hexagon [-C, 5C]
    always_comb begin
        if (bus.V_i < bus.S_i) begin
            c_s = bus.V_i;
        end else begin
            c_s = bus.S_i;
        end
        c_ext_s = $signed({{(HW-CW){1'b0}}, c_s});
        c5_s    = (c_ext_s <<< 2) + c_ext_s;
        cneg_s  = -c_ext_s;
        if (bus.H_i < cneg_s) begin
            h1_d = cneg_s;
        end else if (bus.H_i > c5_s) begin
            h1_d = c5_s;
        end else begin
            h1_d = bus.H_i;
        end
        c1_d   = c_s;
        v1_d   = bus.V_i;
        m1_d   = bus.V_i - c_s;
        vld1_d = bus.in_valid;
        sof1_d = bus.sof_i;
        eol1_d = bus.eol_i;
    end

    // Stage 1 register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld1_q <= 1'b0;
            h1_q   <= {HW{1'b0}};
            c1_q   <= {CW{1'b0}};
            v1_q   <= {CW{1'b0}};
            m1_q   <= {CW{1'b0}};
            sof1_q <= 1'b0;
            eol1_q <= 1'b0;
        end else if (en_s) begin
            vld1_q <= vld1_d;
            h1_q   <= h1_d;
            c1_q   <= c1_d;
            v1_q   <= v1_d;
            m1_q   <= m1_d;
            sof1_q <= sof1_d;
            eol1_q <= eol1_d;
        end
    end

    // Stage 2 next state: first matching sector wins, so H==C and H==3C land in the later one
    always_comb begin
        c1x_s = $signed({{(HW-CW){1'b0}}, c1_q});
        if (h1_q < c1x_s) begin
            sec2_d = SEC_R;
            x2_d   = h1_q;
        end else if (h1_q < ((c1x_s <<< 1) + c1x_s)) begin
            sec2_d = SEC_G;
            x2_d   = h1_q - (c1x_s <<< 1);
        end else begin
            sec2_d = SEC_B;
            x2_d   = h1_q - (c1x_s <<< 2);
        end
    end

    // Stage 2 register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld2_q <= 1'b0;
            sec2_q <= SEC_R;
            x2_q   <= {HW{1'b0}};
            v2_q   <= {CW{1'b0}};
            m2_q   <= {CW{1'b0}};
            sof2_q <= 1'b0;
            eol2_q <= 1'b0;
        end else if (en_s) begin
            vld2_q <= vld1_q;
            sec2_q <= sec2_d;
            x2_q   <= x2_d;
            v2_q   <= v1_q;
            m2_q   <= m1_q;
            sof2_q <= sof1_q;
            eol2_q <= eol1_q;
        end
    end

    // Stage 3 next state: max channel is V, the sign of x picks which other channel rises above m
    always_comb begin
        m_ext_s = $signed({{(HW-CW){1'b0}}, m2_q});
        add_s   = m_ext_s + x2_q;
        sub_s   = m_ext_s - x2_q;
        r3_d    = m2_q;
        g3_d    = m2_q;
        b3_d    = m2_q;
        case (sec2_q)
            SEC_R: begin
                r3_d = v2_q;
                if (!x2_q[HW-1]) begin
                    g3_d = sat_chan(add_s);
                    b3_d = m2_q;
                end else begin
                    g3_d = m2_q;
                    b3_d = sat_chan(sub_s);
                end
            end
            SEC_G: begin
                g3_d = v2_q;
                if (!x2_q[HW-1]) begin
                    b3_d = sat_chan(add_s);
                    r3_d = m2_q;
                end else begin
                    b3_d = m2_q;
                    r3_d = sat_chan(sub_s);
                end
            end
            SEC_B: begin
                b3_d = v2_q;
                if (!x2_q[HW-1]) begin
                    r3_d = sat_chan(add_s);
                    g3_d = m2_q;
                end else begin
                    r3_d = m2_q;
                    g3_d = sat_chan(sub_s);
                end
            end
            default: begin
                r3_d = v2_q;
                g3_d = v2_q;
                b3_d = v2_q;
            end
        endcase
    end

    // Stage 3 register drives the outputs directly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            r_q         <= {CW{1'b0}};
            g_q         <= {CW{1'b0}};
            b_q         <= {CW{1'b0}};
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
        end else if (en_s) begin
            out_valid_q <= vld2_q;
            r_q         <= r3_d;
            g_q         <= g3_d;
            b_q         <= b3_d;
            sof_q       <= sof2_q;
            eol_q       <= eol2_q;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.R_o       = r_q;
    assign bus.G_o       = g_q;
    assign bus.B_o       = b_q;
    assign bus.sof_o     = sof_q;
    assign bus.eol_o     = eol_q;
endmodule

// File: tb/tb_hsv_to_rgb.sv
// Bench for hsv_to_rgb: directed vectors, stalled and random streams, mid-stream reset
// and a boundary sweep, checked against a hexagon-distance colour model.
module tb_hsv_to_rgb;
    localparam int HW = 14;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hsv_to_rgb_if #(.HW(HW), .CW(CW)) bus ();
    hsv_to_rgb #(.HW(HW), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct packed { int h; int s; int v; bit sof; bit eol; } pix_t;
    typedef struct packed { int r; int g; int b; bit sof; bit eol; } exp_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Channel level from circular distance between hue and the channel's primary on a 6C ring
    function automatic int hex_chan(int h, int c, int m, int v, int center);
        int ad, d;
        ad = h - center;
        if (ad < 0) ad = -ad;
        d = (6 * c - ad < ad) ? 6 * c - ad : ad;
        if (d <= c) return v;
        if (d >= 2 * c) return m;
        return v - (d - c);
    endfunction

    function automatic exp_t ref_model(pix_t p);
        exp_t e;
        int c, m, h;
        c = (p.s < p.v) ? p.s : p.v;
        m = p.v - c;
        h = p.h;
        if (h < -c) h = -c;
        if (h > 5 * c) h = 5 * c;
        e.r = hex_chan(h, c, m, p.v, 0);
        e.g = hex_chan(h, c, m, p.v, 2 * c);
        e.b = hex_chan(h, c, m, p.v, 4 * c);
        e.sof = p.sof;
        e.eol = p.eol;
        return e;
    endfunction

    function automatic pix_t rand_pix(bit sof, bit eol);
        pix_t p;
        p.v = int'($urandom_range(0, 255));
        p.s = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, p.v));
        p.h = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 16000)) - 8000
                                           : int'($urandom_range(0, 3000)) - 1500;
        p.sof = sof;
        p.eol = eol;
        return p;
    endfunction

    task automatic drive_pix(input pix_t p, input bit vld);
        bus.in_valid = vld;
        bus.H_i      = HW'(p.h);
        bus.S_i      = CW'(p.s);
        bus.V_i      = CW'(p.v);
        bus.sof_i    = p.sof;
        bus.eol_i    = p.eol;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.R_o !== 8'd0 || bus.G_o !== 8'd0 || bus.B_o !== 8'd0 ||
            bus.sof_o !== 1'b0 || bus.eol_o !== 1'b0)
            $display("FAIL reset_outputs: got v=%b R=%0d G=%0d B=%0d sof=%b eol=%b, want all 0",
                     bus.out_valid, bus.R_o, bus.G_o, bus.B_o, bus.sof_o, bus.eol_o);
        else n_pass++;
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_directed();
        pix_t vec[9];
        int er[9], eg[9], eb[9];
        int lat, gr, gg, gb;
        bit gs, ge;
        vec[0] = '{0, 255, 255, 1'b1, 1'b0};   er[0] = 255; eg[0] = 0;   eb[0] = 0;
        vec[1] = '{510, 255, 255, 1'b0, 1'b1}; er[1] = 0;   eg[1] = 255; eb[1] = 0;
        vec[2] = '{-100, 200, 220, 1'b1, 1'b1}; er[2] = 220; eg[2] = 20; eb[2] = 120;
        vec[3] = '{900, 200, 220, 1'b0, 1'b0}; er[3] = 120; eg[3] = 20;  eb[3] = 220;
        vec[4] = '{37, 0, 128, 1'b0, 1'b1};    er[4] = 128; eg[4] = 128; eb[4] = 128;
        vec[5] = '{-500, 250, 100, 1'b1, 1'b0}; er[5] = 100; eg[5] = 0;  eb[5] = 100;
        vec[6] = '{100, 100, 150, 1'b0, 1'b0}; er[6] = 150; eg[6] = 150; eb[6] = 50;
        vec[7] = '{300, 100, 150, 1'b0, 1'b1}; er[7] = 50;  eg[7] = 150; eb[7] = 150;
        vec[8] = '{5, 0, 0, 1'b1, 1'b1};       er[8] = 0;   eg[8] = 0;   eb[8] = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            drive_pix(vec[i], 1'b1);
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b1) $display("FAIL dir_accept[%0d]: in_ready=%b want 1", i, bus.in_ready);
            else n_pass++;
            lat = 0; gr = 0; gg = 0; gb = 0; gs = 1'b0; ge = 1'b0;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                if (k == 1) bus.in_valid = 1'b0;
                if (lat == 0 && bus.out_valid === 1'b1) begin
                    lat = k; gr = int'(bus.R_o); gg = int'(bus.G_o); gb = int'(bus.B_o);
                    gs = bus.sof_o; ge = bus.eol_o;
                end
            end
            n_checks++;
            if (lat != 3) $display("FAIL dir_latency[%0d]: got %0d cycles want 3", i, lat);
            else n_pass++;
            n_checks++;
            if (gr != er[i] || gg != eg[i] || gb != eb[i] || gs != vec[i].sof || ge != vec[i].eol)
                $display("FAIL dir_rgb[%0d]: got %0d,%0d,%0d sof=%b eol=%b want %0d,%0d,%0d sof=%b eol=%b",
                         i, gr, gg, gb, gs, ge, er[i], eg[i], eb[i], vec[i].sof, vec[i].eol);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        pix_t stim[16];
        exp_t q[$];
        exp_t e;
        bit pat[4];
        int idx, rcv, cyc;
        bit stall_prev;
        logic [7:0] sr, sg, sb;
        logic ss, se;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        for (int i = 0; i < 16; i++) stim[i] = rand_pix(i == 0, (i % 4) == 3);
        idx = 0; rcv = 0; cyc = 0; stall_prev = 1'b0;
        sr = 8'd0; sg = 8'd0; sb = 8'd0; ss = 1'b0; se = 1'b0;
        while (rcv < 16 && cyc < 300) begin
            @(negedge clk);
            if (stall_prev) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.R_o !== sr || bus.G_o !== sg || bus.B_o !== sb ||
                    bus.sof_o !== ss || bus.eol_o !== se)
                    $display("FAIL b2b_stable cyc %0d: got %0d,%0d,%0d want %0d,%0d,%0d held",
                             cyc, bus.R_o, bus.G_o, bus.B_o, sr, sg, sb);
                else n_pass++;
            end
            bus.out_ready = pat[cyc % 4];
            if (idx < 16) drive_pix(stim[idx], 1'b1);
            else bus.in_valid = 1'b0;
            #1;
            n_checks++;
            if (bus.in_ready !== !(bus.out_valid && !bus.out_ready))
                $display("FAIL b2b_in_ready cyc %0d: got %b with out_valid=%b out_ready=%b",
                         cyc, bus.in_ready, bus.out_valid, bus.out_ready);
            else n_pass++;
            stall_prev = bus.out_valid && !bus.out_ready;
            sr = bus.R_o; sg = bus.G_o; sb = bus.B_o; ss = bus.sof_o; se = bus.eol_o;
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (q.size() == 0) $display("FAIL b2b_extra: output with nothing outstanding");
                else begin
                    e = q.pop_front();
                    if (int'(bus.R_o) != e.r || int'(bus.G_o) != e.g || int'(bus.B_o) != e.b ||
                        bus.sof_o !== e.sof || bus.eol_o !== e.eol)
                        $display("FAIL b2b_pix[%0d]: got %0d,%0d,%0d sof=%b eol=%b want %0d,%0d,%0d sof=%b eol=%b",
                                 rcv, bus.R_o, bus.G_o, bus.B_o, bus.sof_o, bus.eol_o, e.r, e.g, e.b, e.sof, e.eol);
                    else n_pass++;
                end
                rcv++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(ref_model(stim[idx]));
                idx++;
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (rcv != 16 || q.size() != 0) $display("FAIL b2b_count: got %0d outputs, %0d left, want 16, 0", rcv, q.size());
        else n_pass++;
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        pix_t p;
        int idx, rcv, cyc;
        bit have;
        idx = 0; rcv = 0; cyc = 0; have = 1'b0;
        p = rand_pix(1'b0, 1'b0);
        while (rcv < 300 && cyc < 3000) begin
            @(negedge clk);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!have && idx < 300 && $urandom_range(0, 4) != 0) begin
                p = rand_pix($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
                have = 1'b1;
            end
            drive_pix(p, have);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (q.size() == 0) $display("FAIL rnd_extra: output with nothing outstanding");
                else begin
                    e = q.pop_front();
                    if (int'(bus.R_o) != e.r || int'(bus.G_o) != e.g || int'(bus.B_o) != e.b ||
                        bus.sof_o !== e.sof || bus.eol_o !== e.eol)
                        $display("FAIL rnd_pix[%0d]: got %0d,%0d,%0d sof=%b eol=%b want %0d,%0d,%0d sof=%b eol=%b",
                                 rcv, bus.R_o, bus.G_o, bus.B_o, bus.sof_o, bus.eol_o, e.r, e.g, e.b, e.sof, e.eol);
                    else n_pass++;
                end
                rcv++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(ref_model(p));
                idx++;
                have = 1'b0;
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (rcv != 300 || q.size() != 0) $display("FAIL rnd_count: got %0d outputs, %0d left, want 300, 0", rcv, q.size());
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int stale;
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_pix(rand_pix(1'b1, 1'b1), 1'b1);
            @(negedge clk);
        end
        n_checks++;
        if (bus.out_valid !== 1'b1) $display("FAIL mid_inflight: out_valid=%b want 1", bus.out_valid);
        else n_pass++;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.R_o !== 8'd0 || bus.G_o !== 8'd0 || bus.B_o !== 8'd0 ||
            bus.sof_o !== 1'b0 || bus.eol_o !== 1'b0)
            $display("FAIL mid_reset_outputs: got v=%b R=%0d G=%0d B=%0d sof=%b eol=%b, want all 0",
                     bus.out_valid, bus.R_o, bus.G_o, bus.B_o, bus.sof_o, bus.eol_o);
        else n_pass++;
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) stale++;
        end
        n_checks++;
        if (stale != 0) $display("FAIL mid_stale: got %0d valid cycles after release, want 0", stale);
        else n_pass++;
    endtask

    task automatic test_sweep();
        pix_t stim[$];
        pix_t inq[$];
        exp_t q[$];
        exp_t e;
        pix_t p, op;
        int idx, rcv, cyc, n, mx, mn;
        for (int v = 0; v <= 255; v++)
            for (int s = 0; s <= v; s++)
                if (s % 7 == 0 || s == v) begin
                    stim.push_back('{-s, s, v, 1'b0, 1'b0});
                    stim.push_back('{s, s, v, 1'b1, 1'b0});
                    stim.push_back('{3 * s, s, v, 1'b0, 1'b1});
                    stim.push_back('{5 * s, s, v, 1'b1, 1'b1});
                end
        n = stim.size();
        idx = 0; rcv = 0; cyc = 0;
        while (rcv < n && cyc < n + 100) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            if (idx < n) begin p = stim[idx]; drive_pix(p, 1'b1); end
            else bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (q.size() == 0) $display("FAIL swp_extra: output with nothing outstanding");
                else begin
                    e = q.pop_front();
                    op = inq.pop_front();
                    if (int'(bus.R_o) != e.r || int'(bus.G_o) != e.g || int'(bus.B_o) != e.b ||
                        bus.sof_o !== e.sof || bus.eol_o !== e.eol)
                        $display("FAIL swp_pix H=%0d S=%0d V=%0d: got %0d,%0d,%0d want %0d,%0d,%0d",
                                 op.h, op.s, op.v, bus.R_o, bus.G_o, bus.B_o, e.r, e.g, e.b);
                    else n_pass++;
                    mx = int'(bus.R_o); mn = int'(bus.R_o);
                    if (int'(bus.G_o) > mx) mx = int'(bus.G_o);
                    if (int'(bus.B_o) > mx) mx = int'(bus.B_o);
                    if (int'(bus.G_o) < mn) mn = int'(bus.G_o);
                    if (int'(bus.B_o) < mn) mn = int'(bus.B_o);
                    n_checks++;
                    if (mx > op.v || mn != op.v - op.s)
                        $display("FAIL swp_bounds H=%0d S=%0d V=%0d: got max %0d min %0d want max<=%0d min %0d",
                                 op.h, op.s, op.v, mx, mn, op.v, op.v - op.s);
                    else n_pass++;
                end
                rcv++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(ref_model(p));
                inq.push_back(p);
                idx++;
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (rcv != n) $display("FAIL swp_count: got %0d outputs want %0d", rcv, n);
        else n_pass++;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.H_i       = 14'sd0;
        bus.S_i       = 8'd0;
        bus.V_i       = 8'd0;
        bus.sof_i     = 1'b0;
        bus.eol_i     = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_mid_reset();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
